// File: rtl/fxp_mult_pipe.sv
// rtl/fxp_mult_pipe.sv - three-stage fixed-point multiplier with Q rescale, saturation, valid/ready and tag
// Optional rounding before the FRAC shift is enabled by defining FXP_MULT_ROUND_EN.
module fxp_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_full,
  output logic [WIDTH-1:0]   out_q,
  output logic               out_ovf,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = 2 * WIDTH;

  logic             adv;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_signed;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [PW-1:0]    s2_prod;
  logic             s2_signed;
  logic [TAG_W-1:0] s2_tag;

  logic [PW-1:0]    ext_a;
  logic [PW-1:0]    ext_b;
  logic [PW-1:0]    prod;

  logic [PW:0]      wide;
  logic [PW:0]      rounded;
  logic [PW:0]      shifted;
  logic [WIDTH-1:0] q_val;
  logic             ovf_val;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Extending both operands to 2*WIDTH lets one truncated multiply serve both modes.
  assign ext_a = in_signed_ext(s1_a, s1_signed);
  assign ext_b = in_signed_ext(s1_b, s1_signed);
  assign prod  = ext_a * ext_b;

  function automatic logic [PW-1:0] in_signed_ext(input logic [WIDTH-1:0] v, input logic s);
    in_signed_ext = {{WIDTH{s & v[WIDTH-1]}}, v};
  endfunction

  assign wide = {s2_signed & s2_prod[PW-1], s2_prod};

`ifdef FXP_MULT_ROUND_EN
  localparam logic [PW:0] RND = (FRAC > 0) ?
      ({{PW{1'b0}}, 1'b1} << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
  assign rounded = wide + RND;
`else
  assign rounded = wide;
`endif

  // Unsigned values keep bit PW clear, so one arithmetic shift covers both modes.
  assign shifted = $signed(rounded) >>> FRAC;

  always_comb begin
    q_val   = shifted[WIDTH-1:0];
    ovf_val = 1'b0;
    if (s2_signed) begin
      if (shifted[PW:WIDTH-1] != {(PW - WIDTH + 2){shifted[PW]}}) begin
        ovf_val = 1'b1;
        q_val   = shifted[PW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else if (|shifted[PW:WIDTH]) begin
      ovf_val = 1'b1;
      q_val   = {WIDTH{1'b1}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_signed <= 1'b0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_prod   <= '0;
      s2_signed <= 1'b0;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      out_full  <= '0;
      out_q     <= '0;
      out_ovf   <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= in_a;
        s1_b      <= in_b;
        s1_signed <= in_signed;
        s1_tag    <= in_tag;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod   <= prod;
        s2_signed <= s1_signed;
        s2_tag    <= s1_tag;
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_full <= s2_prod;
        out_q    <= q_val;
        out_ovf  <= ovf_val;
        out_tag  <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// tb/tb_fxp_mult_pipe.sv - scoreboard bench for fxp_mult_pipe (WIDTH=16, FRAC=8)
module tb_fxp_mult_pipe;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [31:0] full;
    logic [15:0] q;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_full;
  logic [15:0] out_q;
  logic        out_ovf;
  logic [3:0]  out_tag;

  fxp_mult_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_full(out_full), .out_q(out_q), .out_ovf(out_ovf), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  tag_ctr = 4'd0;
  int          stall_left = 0;
  bit          rand_ready = 1'b0;
  bit          gap_chk = 1'b0;
  bit          seen = 1'b0;
  bit          prev_stall = 1'b0;
  logic [52:0] prev_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer product, optional half-LSB bias, floor divide, clamp.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint pa, pb, p, r, lo, hi;
    logic [63:0] pv;
    exp_t e;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    pv = p;
    r  = p;
`ifdef FXP_MULT_ROUND_EN
    if (FRAC > 0) r = r + (longint'(1) <<< (FRAC - 1));
`endif
    r  = r >>> FRAC;
    lo = s ? -(longint'(1) <<< (WIDTH - 1)) : 0;
    hi = s ? (longint'(1) <<< (WIDTH - 1)) - 1 : (longint'(1) <<< WIDTH) - 1;
    e.full = pv[31:0];
    e.ovf  = 1'b0;
    if (r > hi) begin r = hi; e.ovf = 1'b1; end
    if (r < lo) begin r = lo; e.ovf = 1'b1; end
    pv  = r;
    e.q = pv[15:0];
    e.tag = 4'd0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] full, input logic [15:0] q, input logic ovf);
    exp_t e;
    e.full = full; e.q = q; e.ovf = ovf; e.tag = 4'd0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall_left > 0) begin
      stall_left--;
      out_ready = 1'b0;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 9) < 7);
    end else begin
      out_ready = 1'b1;
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s, input exp_t e);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = tag_ctr;
    e.tag = tag_ctr;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        acc = 1'b1;
      end
      tick();
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    tag_ctr  = tag_ctr + 4'd1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [15:0] a, input logic [15:0] b, input logic s);
    send(a, b, s, model(a, b, s));
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [15:0] rnd_op();
    logic [15:0] v;
    case ($urandom_range(0, 9))
      0: v = 16'h7FFF;
      1: v = 16'h8000;
      2: v = 16'hFFFF;
      3: v = 16'h0000;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  // Monitor: protocol checks plus in-order scoreboard comparison.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (prev_stall)
        chk("hold_stable", 64'({out_full, out_q, out_ovf, out_tag}), 64'(prev_out));
      if (gap_chk) begin
        if (out_valid) seen = 1'b1;
        if (seen && sb.size() > 0) chk("no_gap", 64'(out_valid), 64'd1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'({out_tag, out_q}), 64'hDEAD_0000_0000);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", 64'({out_full, out_q, out_ovf, out_tag}), 64'(e));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_full, out_q, out_ovf, out_tag};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({out_full, out_q, out_ovf, out_tag}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Latency of one operation with an always-ready consumer
    send(16'h0180, 16'h0200, 1'b1, mk(32'h00030000, 16'h0300, 1'b0));
    @(negedge clk); chk("lat_n", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk); chk("lat_n1", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk); chk("lat_n2", 64'(out_valid), 64'd1);
    tick();
    drain();

    // Saturation, rounding and mode corners
    send(16'h7FFF, 16'h7FFF, 1'b1, mk(32'h3FFF0001, 16'h7FFF, 1'b1));
    send(16'h8000, 16'h7FFF, 1'b1, mk(32'hC0008000, 16'h8000, 1'b1));
`ifdef FXP_MULT_ROUND_EN
    send(16'h0001, 16'h0080, 1'b1, mk(32'h00000080, 16'h0001, 1'b0));
    send(16'hFFFF, 16'h0080, 1'b1, mk(32'hFFFFFF80, 16'h0000, 1'b0));
`else
    send(16'h0001, 16'h0080, 1'b1, mk(32'h00000080, 16'h0000, 1'b0));
    send(16'hFFFF, 16'h0080, 1'b1, mk(32'hFFFFFF80, 16'hFFFF, 1'b0));
`endif
    send(16'hFFFF, 16'h0100, 1'b0, mk(32'h00FFFF00, 16'hFFFF, 1'b0));
    send(16'hFFFF, 16'h0100, 1'b1, mk(32'hFFFFFF00, 16'hFFFF, 1'b0));
    send(16'hFFFF, 16'hFFFF, 1'b0, mk(32'hFFFE0001, 16'hFFFF, 1'b1));
    drain();

    // Backpressure: six back-to-back tags with a three-cycle stall mid-stream
    tag_ctr = 4'd0;
    gap_chk = 1'b1; seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) stall_left = 3;
      send_m(rnd_op(), rnd_op(), 1'($urandom));
      if (i == 2) stall_left = 3;
    end
    drain();
    gap_chk = 1'b0;

    // Reset with two operations in flight
    send_m(16'h0123, 16'h0456, 1'b1);
    send_m(16'h0789, 16'h0ABC, 1'b0);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_outputs", 64'({out_full, out_q, out_ovf, out_tag}), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    repeat (4) tick();
    send(16'h0180, 16'h0200, 1'b1, mk(32'h00030000, 16'h0300, 1'b0));
    drain();

    // Randomised traffic with random backpressure and input gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send_m(rnd_op(), rnd_op(), 1'($urandom));
    end
    drain();
    rand_ready = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
